pc_unit: RTL and testbench

Program-counter unit for the basic computer. Consumes `jump_enable` from the jump-condition logic plus a target address, and produces the instruction-memory address every cycle. Supports sequential fetch, stall, conditional or unconditional jump, and CALL/RET through a small internal return-address stack. Sits between the control unit / jump logic and the instruction ROM address port.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/ret_stack.sv | 69 ++++++
 rtl/pc_unit.sv | 124 ++++++++++++
 tb/tb_pc_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter unit:
//   DEFAULT_ADDR_W  default program-counter / instruction-address width
//   RESET_VECTOR    address loaded into the PC by reset
//   pc_action_e     the single action taken on a clock edge, listed in
//                   decreasing priority order
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int RESET_VECTOR   = 0;

    typedef enum logic [2:0] {
        PC_RESET,
        PC_HOLD,
        PC_ILLEGAL,
        PC_RET,
        PC_CALL,
        PC_JUMP,
        PC_INC
    } pc_action_e;

endpackage

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
// LIFO of STACK_DEPTH entries, each ADDR_W bits wide, holding return
// addresses for CALL/RET.
//   clk, reset  clock and synchronous active-high reset (clears depth only)
//   push        write push_data on top (ignored when full)
//   pop         discard the top entry (ignored when empty)
//   push_data   value to push
//   top         current top entry (don't-care when empty)
//   depth       number of valid entries
//   full/empty  depth == STACK_DEPTH / depth == 0
// If push and pop arrive together, push wins; pc_unit never asks for both.
// ---------------------------------------------------------------------------
module ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [DW-1:0]     depth,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full    = (depth == DW'(STACK_DEPTH));
    assign empty   = (depth == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !do_push;

    // Entry i is written when depth == i, so the stack grows from index 0.
    // Contents need no reset because depth alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (do_push && (depth == DW'(i))) begin
                mem[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (do_push) begin
            depth <= depth + DW'(1);
        end else if (do_pop) begin
            depth <= depth - DW'(1);
        end
    end

    // Select mem[depth-1] without a variable-width index expression.
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth == DW'(i + 1)) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter for the basic computer: sequential fetch, stall, jump,
// and CALL/RET through an internal return-address stack.
//   clk, reset   clock and synchronous active-high reset
//   stall        hold all state
//   jump_enable  load jump_addr into the PC
//   jump_addr    jump / call target
//   call         push pc+1, then load jump_addr
//   ret          pop the return address into the PC
//   pc           current instruction address (registered)
//   stack_depth  number of valid return addresses
//   stack_full   stack_depth == STACK_DEPTH
//   stack_empty  stack_depth == 0
//   stack_err    sticky overflow / underflow / call-with-ret flag
// ---------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int STACK_DEPTH = 4,
    localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump_enable,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic [DW-1:0]     stack_depth,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    pc_action_e        action;
    logic [ADDR_W-1:0] pc_next_seq;
    logic [ADDR_W-1:0] stack_top;
    logic              push;
    logic              pop;

    // Natural wrap at 2^ADDR_W, so a call at the last address pushes 0.
    assign pc_next_seq = pc + ADDR_W'(1);

    // Priority decoder: exactly one action per edge.
    always_comb begin
        action = PC_INC;
        if (reset) begin
            action = PC_RESET;
        end else if (stall) begin
            action = PC_HOLD;
        end else if (call && ret) begin
            action = PC_ILLEGAL;
        end else if (ret) begin
            action = PC_RET;
        end else if (call) begin
            action = PC_CALL;
        end else if (jump_enable) begin
            action = PC_JUMP;
        end
    end

    // Overflowing calls and underflowing returns never reach the stack.
    assign push = (action == PC_CALL) && !stack_full;
    assign pop  = (action == PC_RET)  && !stack_empty;

    ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_next_seq),
        .top       (stack_top),
        .depth     (stack_depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // Failed stack operations and call+ret fall through to pc+1 and raise
    // the sticky error flag; stack_err itself never changes control flow.
    always_ff @(posedge clk) begin
        case (action)
            PC_RESET: begin
                pc        <= ADDR_W'(RESET_VECTOR);
                stack_err <= 1'b0;
            end
            PC_HOLD: begin
                pc <= pc;
            end
            PC_ILLEGAL: begin
                pc        <= pc_next_seq;
                stack_err <= 1'b1;
            end
            PC_RET: begin
                if (!stack_empty) begin
                    pc <= stack_top;
                end else begin
                    pc        <= pc_next_seq;
                    stack_err <= 1'b1;
                end
            end
            PC_CALL: begin
                if (!stack_full) begin
                    pc <= jump_addr;
                end else begin
                    pc        <= pc_next_seq;
                    stack_err <= 1'b1;
                end
            end
            PC_JUMP: begin
                pc <= jump_addr;
            end
            default: begin
                pc <= pc_next_seq;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Directed vectors with hand-computed expectations. Each stimulus step
// queues the state expected after its clock edge; an independent monitor
// pops and compares on the following falling edge.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int DW          = $clog2(STACK_DEPTH + 1);

    typedef struct {
        int                step_id;
        logic [ADDR_W-1:0] pc;
        logic [DW-1:0]     depth;
        logic              err;
    } expect_t;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              jump_enable;
    logic [ADDR_W-1:0] jump_addr;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic [DW-1:0]     stack_depth;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    expect_t scoreboard[$];
    int      total;
    int      bad;
    int      step_count;

    pc_unit #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jump_enable (jump_enable),
        .jump_addr   (jump_addr),
        .call        (call),
        .ret         (ret),
        .pc          (pc),
        .stack_depth (stack_depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one field and record the outcome.
    task automatic checkOutput(input string what, input int step_id,
                               input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s step=%0d actual=0x%0h required=0x%0h",
                     what, step_id, actual, required);
        end
    endtask

    // Monitor: the DUT presents a new state every cycle.
    always @(negedge clk) begin
        if (scoreboard.size() > 0) begin
            expect_t e;
            e = scoreboard.pop_front();
            checkOutput("pc",    e.step_id, int'(pc),          int'(e.pc));
            checkOutput("depth", e.step_id, int'(stack_depth), int'(e.depth));
            checkOutput("full",  e.step_id, int'(stack_full),
                        int'(e.depth == DW'(STACK_DEPTH)));
            checkOutput("empty", e.step_id, int'(stack_empty),
                        int'(e.depth == '0));
            checkOutput("err",   e.step_id, int'(stack_err),   int'(e.err));
        end
    end

    // Drive one cycle of controls and queue the expected post-edge state.
    task automatic applyStimulus(input logic rst, input logic stl,
                                 input logic je, input logic cl,
                                 input logic rt, input logic [ADDR_W-1:0] addr,
                                 input logic [ADDR_W-1:0] exp_pc,
                                 input int exp_depth, input logic exp_err);
        expect_t e;
        reset       = rst;
        stall       = stl;
        jump_enable = je;
        call        = cl;
        ret         = rt;
        jump_addr   = addr;
        @(posedge clk);
        #1;
        step_count++;
        e.step_id = step_count;
        e.pc      = exp_pc;
        e.depth   = DW'(exp_depth);
        e.err     = exp_err;
        scoreboard.push_back(e);
        reset       = 1'b0;
        stall       = 1'b0;
        jump_enable = 1'b0;
        call        = 1'b0;
        ret         = 1'b0;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    endtask

    task automatic idle(input logic [ADDR_W-1:0] exp_pc, input int d,
                        input logic er);
        applyStimulus(0, 0, 0, 0, 0, 8'h00, exp_pc, d, er);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        step_count  = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        jump_enable = 1'b0;
        call        = 1'b0;
        ret         = 1'b0;
        jump_addr   = '0;
        @(posedge clk);
        #1;

        // Reset then free-run
        doReset();
        for (int i = 1; i <= 5; i++) idle(ADDR_W'(i), 0, 0);

        // Jump and stall (stall also overrides a pending call)
        doReset();
        for (int i = 1; i <= 3; i++) idle(ADDR_W'(i), 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 8'h40, 8'h40, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h40, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 8'h77, 8'h40, 0, 0);
        idle(8'h41, 0, 0);

        // Nested call / return, then back-to-back call+ret
        doReset();
        idle(8'h01, 0, 0);
        idle(8'h02, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 8'h10, 8'h10, 1, 0);
        idle(8'h11, 1, 0);
        applyStimulus(0, 0, 1, 1, 0, 8'h20, 8'h20, 2, 0);
        applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h12, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h03, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 8'h50, 8'h50, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h04, 0, 0);

        // Overflow: error is sticky and does not disturb later pops
        doReset();
        applyStimulus(0, 0, 0, 1, 0, 8'h10, 8'h10, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 8'h20, 8'h20, 2, 0);
        applyStimulus(0, 0, 0, 1, 0, 8'h28, 8'h28, 3, 0);
        applyStimulus(0, 0, 0, 1, 0, 8'h2F, 8'h2F, 4, 0);
        idle(8'h30, 4, 0);
        applyStimulus(0, 0, 0, 1, 0, 8'h70, 8'h31, 4, 1);
        idle(8'h32, 4, 1);
        applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h29, 3, 1);
        applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h21, 2, 1);

        // Underflow
        doReset();
        for (int i = 1; i <= 7; i++) idle(ADDR_W'(i), 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h08, 0, 1);

        // Illegal call+ret
        doReset();
        for (int i = 1; i <= 5; i++) idle(ADDR_W'(i), 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 8'h90, 8'h06, 0, 1);

        // Wrap-around and reset priority
        doReset();
        applyStimulus(0, 0, 1, 0, 0, 8'hFF, 8'hFF, 0, 0);
        idle(8'h00, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 8'hFF, 8'hFF, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 8'h80, 8'h80, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 8'h44, 8'h44, 1, 0);
        applyStimulus(1, 0, 0, 1, 0, 8'h33, 8'h00, 0, 0);
        idle(8'h01, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h02, 0, 1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && scoreboard.size() > 0; i++) @(posedge clk);
        if (scoreboard.size() > 0) begin
            bad++;
            total++;
            $display("[TB] FAIL drain actual=%0d required=0 pending entries",
                     scoreboard.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
